// File: rtl/ex_muldiv_pkg.sv
// Shared pipeline definitions for the EX-stage multiply/divide unit:
// R-type funct codes, unit state encoding and small operand helpers.
package ex_muldiv_pkg;

    localparam int DATA_W = 32;
    localparam int ACC_W  = 2 * DATA_W;

    localparam logic [5:0] FUN_MTHI  = 6'h11;
    localparam logic [5:0] FUN_MTLO  = 6'h13;
    localparam logic [5:0] FUN_MULT  = 6'h18;
    localparam logic [5:0] FUN_MULTU = 6'h19;
    localparam logic [5:0] FUN_DIV   = 6'h1A;
    localparam logic [5:0] FUN_DIVU  = 6'h1B;

    localparam logic [4:0] CNT_FIRST = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } mdState_t;

    function automatic logic isMulDiv(input logic [5:0] fun);
        return (fun == FUN_MULT) || (fun == FUN_MULTU) ||
               (fun == FUN_DIV)  || (fun == FUN_DIVU);
    endfunction

    function automatic logic isDivide(input logic [5:0] fun);
        return (fun == FUN_DIV) || (fun == FUN_DIVU);
    endfunction

    function automatic logic isSignedOp(input logic [5:0] fun);
        return (fun == FUN_MULT) || (fun == FUN_DIV);
    endfunction

    // Magnitude of a two's complement value; 0x80000000 maps to itself, which
    // is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] absVal(input logic signed [DATA_W-1:0] v);
        return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit for the EX stage: 32 shift-add or
// restoring-divide steps on one shared 64-bit accumulator, then sign fix-up.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              iStart,
    input  logic [5:0]        iFun,
    input  logic [DATA_W-1:0] iRegOut1,
    input  logic [DATA_W-1:0] iRegOut2,
    input  logic              iKill,
    output logic              oBusy,
    output logic [DATA_W-1:0] oHi,
    output logic [DATA_W-1:0] oLo
);

    mdState_t          state;
    logic [4:0]        cnt;
    logic              opIsDiv;
    logic              sgnRes;
    logic              sgnRem;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] hiReg;
    logic [DATA_W-1:0] loReg;

    logic signed [DATA_W-1:0] rsS;
    logic signed [DATA_W-1:0] rtS;
    logic [DATA_W-1:0] rsMag;
    logic [DATA_W-1:0] rtMag;
    logic              funMulDiv;
    logic              funDiv;
    logic              funSigned;
    logic              accept;
    logic              divZero;

    logic [DATA_W:0]   mulSum;
    logic [ACC_W-1:0]  mulStep;
    logic [ACC_W:0]    divShift;
    logic              divFits;
    logic [DATA_W-1:0] divDiff;
    logic [ACC_W-1:0]  divStep;

    logic [ACC_W-1:0]  prodFix;
    logic [DATA_W-1:0] quotFix;
    logic [DATA_W-1:0] remFix;

    function automatic logic [ACC_W-1:0] condNeg64(input logic [ACC_W-1:0] v, input logic neg);
        return neg ? ACC_W'(-v) : v;
    endfunction

    function automatic logic [DATA_W-1:0] condNeg32(input logic [DATA_W-1:0] v, input logic neg);
        return neg ? DATA_W'(-v) : v;
    endfunction

    assign rsS       = iRegOut1;
    assign rtS       = iRegOut2;
    assign funMulDiv = isMulDiv(iFun);
    assign funDiv    = isDivide(iFun);
    assign funSigned = isSignedOp(iFun);
    assign rsMag     = funSigned ? absVal(rsS) : iRegOut1;
    assign rtMag     = funSigned ? absVal(rtS) : iRegOut2;
    assign divZero   = funDiv && (iRegOut2 == '0);
    assign accept    = (state == ST_IDLE) && iStart && !iKill;

    // Stall covers the accept cycle itself so ID/EX holds the instruction.
    assign oBusy = ((state != ST_IDLE) && !rst) ||
                   ((state == ST_IDLE) && iStart && funMulDiv);

    assign oHi = hiReg;
    assign oLo = loReg;

    // Multiply step: conditional add of the multiplicand into the upper half,
    // then shift the whole 65-bit sum right by one.
    assign mulSum  = {1'b0, acc[ACC_W-1:DATA_W]} + (acc[0] ? {1'b0, opB} : '0);
    assign mulStep = {mulSum, acc[DATA_W-1:1]};

    // Restoring divide step: shift left, trial-subtract divisor from the
    // 33-bit partial remainder, keep the difference and set a quotient bit.
    assign divShift = {acc, 1'b0};
    assign divFits  = divShift[ACC_W:DATA_W] >= {1'b0, opB};
    assign divDiff  = divShift[ACC_W-1:DATA_W] - opB;
    assign divStep  = divFits ? {divDiff, divShift[DATA_W-1:1], 1'b1}
                              : divShift[ACC_W-1:0];

    assign prodFix = condNeg64(acc, sgnRes);
    assign quotFix = condNeg32(acc[DATA_W-1:0], sgnRes);
    assign remFix  = condNeg32(acc[ACC_W-1:DATA_W], sgnRem);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            opIsDiv <= 1'b0;
            sgnRes  <= 1'b0;
            sgnRem  <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (iFun == FUN_MTHI) begin
                            hiReg <= iRegOut1;
                        end else if (iFun == FUN_MTLO) begin
                            loReg <= iRegOut1;
                        end else if (funMulDiv) begin
                            cnt     <= CNT_FIRST;
                            opIsDiv <= funDiv;
                            // Divide-by-zero result is preloaded raw, so no fix-up sign.
                            sgnRes  <= funSigned && !divZero && (iRegOut1[DATA_W-1] ^ iRegOut2[DATA_W-1]);
                            sgnRem  <= (iFun == FUN_DIV) && !divZero && iRegOut1[DATA_W-1];
                            state   <= divZero ? ST_FIX : ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (iKill) begin
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        state <= ST_FIX;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ST_FIX: begin
                    if (!iKill) begin
                        if (opIsDiv) begin
                            hiReg <= remFix;
                            loReg <= quotFix;
                        end else begin
                            hiReg <= prodFix[ACC_W-1:DATA_W];
                            loReg <= prodFix[DATA_W-1:0];
                        end
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept && funMulDiv) begin
            opB <= rtMag;
            acc <= divZero ? {iRegOut1, {DATA_W{1'b1}}} : {{DATA_W{1'b0}}, rsMag};
        end else if (state == ST_CALC) begin
            acc <= opIsDiv ? divStep : mulStep;
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed HI/LO scenarios with literal results plus a
// randomized run checked every cycle against an arithmetic reference model.
module tb_ex_muldiv;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic        clk = 1'b0;
    logic        rst;
    logic        iStart;
    logic [5:0]  iFun;
    logic [31:0] iRegOut1;
    logic [31:0] iRegOut2;
    logic        iKill;
    logic        oBusy;
    logic [31:0] oHi;
    logic [31:0] oLo;

    int nChecks = 0;
    int nErrors = 0;

    // Reference model: cycles of busy remaining after the accept edge, the
    // architectural HI/LO and the pending result of the op in flight.
    int          remain = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;
    logic [31:0] pHi = '0;
    logic [31:0] pLo = '0;
    bit          modelOn = 1'b0;

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk(clk), .rst(rst), .iStart(iStart), .iFun(iFun),
        .iRegOut1(iRegOut1), .iRegOut2(iRegOut2), .iKill(iKill),
        .oBusy(oBusy), .oHi(oHi), .oLo(oLo)
    );

    function automatic bit mdFun(input logic [5:0] f);
        return (f >= 6'h18) && (f <= 6'h1B);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic computeResult(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            F_MULT: begin
                p = sa * sb;
                pHi = p[63:32]; pLo = p[31:0];
            end
            F_MULTU: begin
                p = {32'h0, a} * {32'h0, b};
                pHi = p[63:32]; pLo = p[31:0];
            end
            F_DIV: begin
                if (b == 0) begin
                    pHi = a; pLo = 32'hFFFF_FFFF;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    pHi = r[31:0]; pLo = q[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    pHi = a; pLo = 32'hFFFF_FFFF;
                end else begin
                    p = {32'h0, a} / {32'h0, b};
                    pLo = p[31:0];
                    p = {32'h0, a} % {32'h0, b};
                    pHi = p[31:0];
                end
            end
        endcase
    endtask

    task automatic modelStep();
        if (rst) begin
            remain  = 0;
            mHi     = '0;
            mLo     = '0;
            modelOn = 1'b1;
        end else if (remain > 0) begin
            if (iKill) begin
                remain = 0;
            end else begin
                remain--;
                if (remain == 0) begin
                    mHi = pHi;
                    mLo = pLo;
                end
            end
        end else if (iStart && !iKill) begin
            if (iFun == F_MTHI) begin
                mHi = iRegOut1;
            end else if (iFun == F_MTLO) begin
                mLo = iRegOut1;
            end else if (mdFun(iFun)) begin
                computeResult(iFun, iRegOut1, iRegOut2);
                remain = ((iFun == F_DIV || iFun == F_DIVU) && iRegOut2 == 0) ? 1 : 33;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (modelOn) begin
            check("cyc_busy", oBusy,
                  ((remain > 0) && !rst) || ((remain == 0) && iStart && mdFun(iFun)));
            check("cyc_hi", oHi, mHi);
            check("cyc_lo", oLo, mLo);
        end
    end

    task automatic runOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eHi, input logic [31:0] eLo, input int eBusy,
                         input bit hold, input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        iStart = 1'b1; iFun = f; iRegOut1 = a; iRegOut2 = b;
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (!oBusy) begin
                done = 1'b1;
            end else begin
                n++;
                tick();
                if (hold && i < 30) begin
                    iFun = F_DIVU; iRegOut1 = $urandom; iRegOut2 = $urandom;
                end else begin
                    iStart = 1'b0;
                end
            end
        end
        iStart = 1'b0;
        check({name, "_busycycles"}, n, eBusy);
        check({name, "_hi"}, oHi, eHi);
        check({name, "_lo"}, oLo, eLo);
        tick();
    endtask

    task automatic moveTo(input logic [5:0] f, input logic [31:0] v);
        iStart = 1'b1; iFun = f; iRegOut1 = v; iRegOut2 = '0;
        #1;
        check("mt_busy", oBusy, 1'b0);
        tick();
        iStart = 1'b0;
    endtask

    // Start MULT 3x4 and run to the start of cycle 10 of the op.
    task automatic startMultTo10();
        iStart = 1'b1; iFun = F_MULT; iRegOut1 = 32'd3; iRegOut2 = 32'd4;
        tick();
        iStart = 1'b0;
        repeat (9) tick();
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] funTab [8];
        funTab = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, 6'h20, 6'h1C};

        rst = 1'b1; iStart = 1'b0; iFun = '0; iRegOut1 = '0; iRegOut2 = '0; iKill = 1'b0;
        tick();
        tick();
        check("rst_hi", oHi, 32'h0);
        check("rst_lo", oLo, 32'h0);
        check("rst_busy", oBusy, 1'b0);
        rst = 1'b0;
        tick();

        runOp(F_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 1'b0, "mult_neg");
        runOp(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 1'b0, "multu_max");
        runOp(F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0, "div_neg7");
        runOp(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 34, 1'b0, "div_ovf");
        runOp(F_DIVU,  32'd100,       32'd0,         32'h64,        32'hFFFF_FFFF, 2,  1'b0, "divu_zero");
        runOp(F_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 2,  1'b0, "div_zero");
        runOp(F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34, 1'b0, "divu_100_7");
        runOp(F_MULTU, 32'd7,         32'd6,         32'd0,         32'd42,        34, 1'b1, "hold_other");

        moveTo(F_MTHI, 32'hAAAA_5555);
        check("mthi_hi", oHi, 32'hAAAA_5555);
        check("mthi_lo", oLo, 32'd42);

        // Unrecognised funct leaves HI/LO alone.
        iStart = 1'b1; iFun = 6'h20; iRegOut1 = 32'hDEAD_BEEF;
        tick();
        iStart = 1'b0;
        check("badfun_hi", oHi, 32'hAAAA_5555);

        // iKill mid-CALC: op abandoned, LO keeps the MTLO value.
        moveTo(F_MTLO, 32'h1234);
        check("mtlo_lo", oLo, 32'h1234);
        startMultTo10();
        iKill = 1'b1;
        #1;
        check("kill_busy_c10", oBusy, 1'b1);
        tick();
        iKill = 1'b0;
        #1;
        check("kill_busy_c11", oBusy, 1'b0);
        repeat (30) tick();
        check("kill_lo", oLo, 32'h1234);
        check("kill_hi", oHi, 32'hAAAA_5555);

        // Kill together with iStart in IDLE blocks acceptance.
        iStart = 1'b1; iKill = 1'b1; iFun = F_MTLO; iRegOut1 = 32'h9999;
        tick();
        iStart = 1'b0; iKill = 1'b0;
        check("killstart_lo", oLo, 32'h1234);

        // Reset mid-CALC clears HI/LO and discards the op.
        startMultTo10();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid_busy", oBusy, 1'b0);
        check("rstmid_hi", oHi, 32'h0);
        check("rstmid_lo", oLo, 32'h0);
        repeat (30) tick();
        check("rstmid_lo_late", oLo, 32'h0);

        for (int c = 0; c < 4000; c++) begin
            iStart   = ($urandom_range(0, 99) < 40);
            iFun     = funTab[$urandom_range(0, 7)];
            iRegOut1 = pickOperand();
            iRegOut2 = pickOperand();
            iKill    = ($urandom_range(0, 199) == 0);
            rst      = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0; iStart = 1'b0; iKill = 1'b0;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port iStart, input, 1, EX-stage instruction valid and not flushed.
REQ-004 SHALL have port iFun, input, 6, R-type funct from ID/EX.
REQ-005 SHALL have port iRegOut1, input, 32, rs operand.
REQ-006 SHALL have port iRegOut2, input, 32, rt operand.
REQ-007 SHALL have port iKill, input, 1, exception abort of in-flight op.
REQ-008 SHALL have port oBusy, output, 1, stall request to ID/EX and upstream stages.
REQ-009 SHALL have port oHi, output, 32, HI register.
REQ-010 SHALL have port oLo, output, 32, LO register.

Function
REQ-011 SHALL recognise funct MULT=0x18, MULTU=0x19, DIV=0x1A, DIVU=0x1B, MTHI=0x11, MTLO=0x13; any other funct with iStart SHALL be ignored.
REQ-012 SHALL implement states IDLE, CALC, FIX; IDLE->CALC on accepted mul/div with nonzero divisor; IDLE->FIX on DIV/DIVU with rt=0; CALC->FIX when iteration counter reaches 0; FIX->IDLE always.
REQ-013 SHALL accept an op only in IDLE with iStart=1; in cycle 0 latch |rs|, |rt| (signed ops) or raw values (unsigned), record result sign, load counter = 31.
REQ-014 SHALL perform one shift-add (multiply) or one restoring subtract-shift (divide) step per CALC cycle: exactly 32 CALC cycles.
REQ-015 In FIX SHALL negate product (64-bit) if result sign set; for divide negate quotient if rs,rt signs differ, negate remainder if rs negative; then write HI/LO.
REQ-016 Multiply: HI/LO = upper/lower 64-bit product; divide: LO = quotient, HI = remainder.
REQ-017 Mul/div latency SHALL be 34 cycles: accept cycle 0, CALC 1..32, FIX 33; new oHi/oLo visible from cycle 34.
REQ-018 oBusy SHALL be combinational: (state!=IDLE) OR (iStart AND funct in MULT..DIVU while IDLE); high cycles 0..33 inclusive, low in cycle 34.
REQ-019 Divide by zero SHALL skip CALC: FIX in cycle 1 writes LO=0xFFFFFFFF, HI=rs; oBusy high cycles 0..1.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0, no trap.
REQ-021 MTHI/MTLO SHALL write HI/LO from rs at end of accept cycle, oBusy stays 0; also allowed only in IDLE.
REQ-022 iStart while not IDLE SHALL be ignored (upstream is held by oBusy).
REQ-023 iKill in any non-IDLE state SHALL return to IDLE next edge with HI/LO unchanged; iKill with iStart in IDLE SHALL block acceptance.
REQ-024 oHi/oLo SHALL be register outputs, unchanged except by REQ-015/019/021.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, HI=0, LO=0, counter=0, sign flags 0; oBusy SHALL read 0 while rst is high unless combinationally raised by iStart.
REQ-026 rst mid-CALC SHALL discard the op; no HI/LO write SHALL occur.
REQ-027 rst SHALL dominate iKill and iStart.

Structure
REQ-028 Funct codes and state encoding SHALL live in the shared pipeline package, reused by the decoder.
REQ-029 SHALL be a single module, no sub-module; 64-bit accumulator/remainder register shared by multiply and divide.
REQ-030 oBusy SHALL drive the stall input of ID/EX and IF/ID.

Verification
REQ-031 MULT rs=0xFFFFFFFD, rt=5 -> cycle 34 HI=0xFFFFFFFF, LO=0xFFFFFFF1; oBusy high exactly 34 cycles.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-033 DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-034 DIVU 100/0 -> oBusy high 2 cycles, LO=0xFFFFFFFF, HI=0x64.
REQ-035 MTLO 0x1234 then MULT 3x4, iKill at cycle 10 -> IDLE at cycle 11, LO stays 0x1234; repeat with rst at cycle 10 -> HI=LO=0.
REQ-036 iStart held during busy with different funct -> ignored, single result written at cycle 34.
